// File: rtl/module_spi_master_ctrl.sv
// SPI mode-0 master controller: frames one DATA_WIDTH-bit transfer per start_i,
// driving SCLK/CS/MOSI and handing sampled MISO bits to an external RX shift register.
module module_spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  cs_o,
    output logic                  mosi_o,
    output logic                  rx_bit_o,
    output logic                  rx_shift_en_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int              BW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [7:0]      HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, TRAIL} state_t;

    state_t                  state_q;
    logic [7:0]              hcnt_q, hcnt_d;
    logic [BW-1:0]           bcnt_q;
    logic [DATA_WIDTH-1:0]   tx_q;
    logic                    sclk_q, cs_q, mosi_q, rx_bit_q, rx_en_q, busy_q, done_q;
    logic                    half_end;

    assign half_end = (hcnt_q == HALF_LAST);
    assign hcnt_d   = half_end ? 8'd0 : hcnt_q + 8'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            bcnt_q   <= '0;
            tx_q     <= '0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            rx_bit_q <= 1'b0;
            rx_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rx_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= SETUP;
                        tx_q    <= data_i;
                        mosi_q  <= data_i[DATA_WIDTH-1];
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        hcnt_q  <= '0;
                        bcnt_q  <= '0;
                    end
                end
                SETUP: begin
                    hcnt_q <= hcnt_d;
                    if (half_end) begin
                        state_q  <= SHIFT;
                        sclk_q   <= 1'b1;
                        rx_bit_q <= miso_i;
                        rx_en_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    hcnt_q <= hcnt_d;
                    if (half_end) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            if (bcnt_q != BIT_LAST) begin
                                tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                                mosi_q <= tx_q[DATA_WIDTH-2];
                            end
                        end else if (bcnt_q == BIT_LAST) begin
                            // low half of the last bit is over; hold MOSI through TRAIL
                            state_q <= TRAIL;
                        end else begin
                            sclk_q   <= 1'b1;
                            bcnt_q   <= bcnt_q + 1'b1;
                            rx_bit_q <= miso_i;
                            rx_en_q  <= 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    hcnt_q <= hcnt_d;
                    if (half_end) begin
                        state_q <= IDLE;
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sclk_o        = sclk_q;
    assign cs_o          = cs_q;
    assign mosi_o        = mosi_q;
    assign rx_bit_o      = rx_bit_q;
    assign rx_shift_en_o = rx_en_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
endmodule

// File: tb/tb_module_spi_master_ctrl.sv
// Directed bench: one DUT at CLK_DIV=4 with optional loopback, one at CLK_DIV=1 in loopback.
module tb_module_spi_master_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, start = 1'b0, loop0 = 1'b0, tie0 = 1'b0;
    logic [7:0] data = 8'h00;
    logic       miso0, sclk, cs, mosi, rxb, rxe, busy, done;
    assign miso0 = loop0 ? mosi : tie0;

    module_spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data), .miso_i(miso0),
        .sclk_o(sclk), .cs_o(cs), .mosi_o(mosi), .rx_bit_o(rxb),
        .rx_shift_en_o(rxe), .busy_o(busy), .done_o(done));

    logic       rst1 = 1'b1, start1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       sclk1, cs1, mosi1, rxb1, rxe1, busy1, done1;

    module_spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .start_i(start1), .data_i(data1), .miso_i(mosi1),
        .sclk_o(sclk1), .cs_o(cs1), .mosi_o(mosi1), .rx_bit_o(rxb1),
        .rx_shift_en_o(rxe1), .busy_o(busy1), .done_o(done1));

    int errors = 0, checks = 0;

    // monitors: cumulative counts, tasks diff snapshots
    int cs_low = 0, pulses = 0, dones = 0, mosi_hi = 0;
    logic [7:0] rx_reg = 8'h00, mosi_seq = 8'h00;
    logic       sclk_prev = 1'b0;
    always @(posedge clk) begin
        sclk_prev <= sclk;
        if (!cs) cs_low <= cs_low + 1;
        if (!cs && mosi) mosi_hi <= mosi_hi + 1;
        if (rxe) begin pulses <= pulses + 1; rx_reg <= {rx_reg[6:0], rxb}; end
        if (done) dones <= dones + 1;
        if (sclk && !sclk_prev) mosi_seq <= {mosi_seq[6:0], mosi};
    end

    int cs_low1 = 0, pulses1 = 0;
    logic [7:0] rx_reg1 = 8'h00;
    always @(posedge clk) begin
        if (!cs1) cs_low1 <= cs_low1 + 1;
        if (rxe1) begin pulses1 <= pulses1 + 1; rx_reg1 <= {rx_reg1[6:0], rxb1}; end
    end

    // Launch one transfer on dut0 and wait for done; optionally poke start_i at cycle 'poke'.
    task automatic run0(input logic [7:0] d, input logic lp, input logic tie, input int poke,
                        output bit ok);
        loop0 = lp; tie0 = tie;
        @(negedge clk); start = 1'b1; data = d;
        @(negedge clk); start = 1'b0; data = ~d;
        ok = 1'b0;
        for (int i = 1; i < 400; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (i == poke) begin start = 1'b1; data = 8'hFF; end
            if (i == poke + 1) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst1 = 1'b1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        if (cs   !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", cs); end
        if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        if (rxb  !== 1'b0) begin errors++; $display("FAIL reset_rx_bit: got %b expected 0", rxb); end
        if (rxe  !== 1'b0) begin errors++; $display("FAIL reset_rx_en: got %b expected 0", rxe); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0; rst1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loopback_a5;
        int b_cs, b_p; bit ok;
        b_cs = cs_low; b_p = pulses;
        run0(8'hA5, 1'b1, 1'b0, -10, ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL a5_timeout: got no done expected done"); end
        if (cs_low - b_cs !== 72) begin errors++; $display("FAIL a5_cs_low: got %0d expected 72", cs_low - b_cs); end
        if (pulses - b_p !== 8) begin errors++; $display("FAIL a5_pulses: got %0d expected 8", pulses - b_p); end
        if (mosi_seq !== 8'hA5) begin errors++; $display("FAIL a5_mosi_seq: got %h expected a5", mosi_seq); end
        if (rx_reg !== 8'hA5) begin errors++; $display("FAIL a5_rx: got %h expected a5", rx_reg); end
        @(negedge clk);
    endtask

    task automatic test_miso_high;
        int b_hi; bit ok;
        b_hi = mosi_hi;
        run0(8'h00, 1'b0, 1'b1, -10, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL ones_timeout: got no done expected done"); end
        if (mosi_hi - b_hi !== 0) begin errors++; $display("FAIL ones_mosi_high_cycles: got %0d expected 0", mosi_hi - b_hi); end
        if (rx_reg !== 8'hFF) begin errors++; $display("FAIL ones_rx: got %h expected ff", rx_reg); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int b_cs, b_d; bit ok;
        b_cs = cs_low; b_d = dones;
        run0(8'h3C, 1'b1, 1'b0, 20, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL busy_timeout: got no done expected done"); end
        if (mosi_seq !== 8'h3C) begin errors++; $display("FAIL busy_mosi_seq: got %h expected 3c", mosi_seq); end
        if (rx_reg !== 8'h3C) begin errors++; $display("FAIL busy_rx: got %h expected 3c", rx_reg); end
        repeat (100) @(negedge clk);
        checks += 2;
        if (cs_low - b_cs !== 72) begin errors++; $display("FAIL busy_cs_low: got %0d expected 72", cs_low - b_cs); end
        if (dones - b_d !== 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", dones - b_d); end
    endtask

    task automatic test_reset_mid;
        int b_p, b_d, seen; bit ok;
        b_p = pulses; b_d = dones; seen = 0; ok = 1'b0;
        loop0 = 1'b1;
        @(negedge clk); start = 1'b1; data = 8'h96;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rxe) seen++;
            if (seen == 3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL rmid_timeout: got %0d pulses expected 3", seen); end
        if (cs !== 1'b1) begin errors++; $display("FAIL rmid_cs: got %b expected 1", cs); end
        if (sclk !== 1'b0) begin errors++; $display("FAIL rmid_sclk: got %b expected 0", sclk); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        if (rxe !== 1'b0) begin errors++; $display("FAIL rmid_rx_en: got %b expected 0", rxe); end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks += 2;
        if (dones - b_d !== 0) begin errors++; $display("FAIL rmid_done: got %0d expected 0", dones - b_d); end
        if (pulses - b_p !== 3) begin errors++; $display("FAIL rmid_pulses: got %0d expected 3", pulses - b_p); end
        run0(8'h5A, 1'b1, 1'b0, -10, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rmid_5a_timeout: got no done expected done"); end
        if (rx_reg !== 8'h5A) begin errors++; $display("FAIL rmid_5a_rx: got %h expected 5a", rx_reg); end
        @(negedge clk);
    endtask

    task automatic test_clkdiv1;
        int b_cs, b_p; bit ok;
        b_cs = cs_low1; b_p = pulses1; ok = 1'b0;
        @(negedge clk); start1 = 1'b1; data1 = 8'hC3;
        @(negedge clk); start1 = 1'b0; data1 = 8'h00;
        for (int i = 0; i < 100; i++) begin
            if (done1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks += 4;
        if (!ok) begin errors++; $display("FAIL div1_timeout: got no done expected done"); end
        if (cs_low1 - b_cs !== 18) begin errors++; $display("FAIL div1_cs_low: got %0d expected 18", cs_low1 - b_cs); end
        if (pulses1 - b_p !== 8) begin errors++; $display("FAIL div1_pulses: got %0d expected 8", pulses1 - b_p); end
        if (rx_reg1 !== 8'hC3) begin errors++; $display("FAIL div1_rx: got %h expected c3", rx_reg1); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int b_cs; bit ok;
        b_cs = cs_low; ok = 1'b0; loop0 = 1'b1;
        @(negedge clk); start = 1'b1; data = 8'h81;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        checks += 2;
        if (!ok) begin errors++; $display("FAIL b2b_timeout1: got no done expected done"); end
        if (cs !== 1'b1) begin errors++; $display("FAIL b2b_gap_cs: got %b expected 1", cs); end
        @(negedge clk);
        start = 1'b0;
        checks += 2;
        if (cs !== 1'b0) begin errors++; $display("FAIL b2b_restart_cs: got %b expected 0", cs); end
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b expected 1", busy); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks += 3;
        if (!ok) begin errors++; $display("FAIL b2b_timeout2: got no done expected done"); end
        if (rx_reg !== 8'h81) begin errors++; $display("FAIL b2b_rx: got %h expected 81", rx_reg); end
        if (cs_low - b_cs !== 144) begin errors++; $display("FAIL b2b_cs_low: got %0d expected 144", cs_low - b_cs); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_loopback_a5;
        test_miso_high;
        test_start_while_busy;
        test_reset_mid;
        test_clkdiv1;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/module_spi_master_ctrl.md
MODULE_SPI_MASTER_CTRL -- requirements
Module: module_spi_master_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per transaction; only 8 is supported.
REQ-002 Parameter CLK_DIV, default 4, clk_i cycles per SCLK half-period; legal range 1..255.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  system clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  request a transaction; sampled only in IDLE.
REQ-007 data_i  input  DATA_WIDTH  transmit word; captured in the cycle start_i is accepted.
REQ-008 miso_i  input  1  serial data from slave.
REQ-009 sclk_o  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 cs_o  output  1  slave select, active-low.
REQ-011 mosi_o  output  1  serial data to slave, MSB first.
REQ-012 rx_bit_o  output  1  registered MISO sample; feeds data_i of the downstream RX shift register.
REQ-013 rx_shift_en_o  output  1  one-cycle pulse; feeds shift_en_i of the downstream RX shift register.
REQ-014 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-015 done_o  output  1  one-cycle pulse at the end of a transaction.

Function
REQ-016 The FSM SHALL have four states: IDLE, SETUP, SHIFT, TRAIL.
REQ-017 IDLE: cs_o=1, sclk_o=0, busy_o=0; start_i=1 at edge -> SETUP, data_i latched into TX register, bit counter=0, half-period counter=0.
REQ-018 On entering SETUP, cs_o=0 and mosi_o=data_i[DATA_WIDTH-1]; SETUP lasts CLK_DIV cycles, then -> SHIFT.
REQ-019 SHIFT: sclk_o toggles every CLK_DIV cycles, starting high; each bit = 2*CLK_DIV cycles.
REQ-020 At every edge where sclk_o goes 0->1, rx_bit_o SHALL load miso_i and rx_shift_en_o SHALL be 1 for exactly that following cycle.
REQ-021 At every edge where sclk_o goes 1->0, except after the last bit, mosi_o SHALL advance to the next lower TX bit.
REQ-022 After the 1->0 edge of bit DATA_WIDTH-1 -> TRAIL; sclk_o stays 0, mosi_o holds the last bit.
REQ-023 TRAIL lasts CLK_DIV cycles; then -> IDLE, cs_o=1, done_o=1 for that single cycle.
REQ-024 Timing: cs_o low for exactly (2*DATA_WIDTH+2)*CLK_DIV cycles (72 at defaults); exactly DATA_WIDTH rx_shift_en_o pulses per transaction.
REQ-025 start_i while busy_o=1 SHALL be ignored, with no effect on TX data or timing.
REQ-026 start_i=1 in the done_o cycle SHALL be accepted; the next cs_o low begins the following cycle.
REQ-027 data_i changes after acceptance SHALL NOT affect mosi_o.
REQ-028 Counters: half-period counter 8 bits, wraps to 0 at CLK_DIV-1; bit counter log2(DATA_WIDTH) bits, no wrap beyond DATA_WIDTH-1.
REQ-029 CLK_DIV=1: sclk_o toggles every cycle; REQ-020 and REQ-021 SHALL still hold.
REQ-030 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 rst_i=1 at an edge SHALL force IDLE: sclk_o=0, cs_o=1, mosi_o=0, rx_bit_o=0, rx_shift_en_o=0, busy_o=0, done_o=0, all counters and TX register to 0.
REQ-032 Reset mid-transaction SHALL abort without issuing done_o; no rx_shift_en_o pulse occurs in or after the reset cycle.
REQ-033 rst_i SHALL take priority over start_i in the same cycle.

Verification
REQ-034 Loopback mosi_o->miso_i, data_i=0xA5, CLK_DIV=4 -> downstream RX register=0xA5 at done_o; 8 shift pulses; cs_o low 72 cycles; MOSI sequence 1,0,1,0,0,1,0,1.
REQ-035 miso_i tied 1, data_i=0x00 -> mosi_o=0 throughout; RX register=0xFF at done_o.
REQ-036 start_i pulsed at cycle 20 of a busy transfer with data_i=0x3C -> transfer completes with its original data; no second transaction.
REQ-037 rst_i asserted after the 3rd rx_shift_en_o pulse -> next cycle cs_o=1, sclk_o=0, busy_o=0; no done_o; a fresh 0x5A transfer then completes correctly.
REQ-038 CLK_DIV=1, loopback 0xC3 -> cs_o low 18 cycles; RX register=0xC3.
REQ-039 start_i held high continuously -> back-to-back transactions; exactly one cycle with cs_o=1 between them (the done_o cycle).
